// File: rtl/sram_pkg.sv
// sram_pkg: shared default widths and arbiter state encoding
package sram_pkg;
  localparam int SRAM_ADDR_WIDTH = 4;
  localparam int SRAM_DATA_WIDTH = 8;
  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;
endpackage

// File: rtl/sram_mem.sv
// sram_mem: single-port storage, synchronous write, registered read, contents never reset
module sram_mem
  import sram_pkg::*;
#(
  parameter int AW = SRAM_ADDR_WIDTH,
  parameter int DW = SRAM_DATA_WIDTH
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;
  // write the addressed word, or capture it for a read
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    if (re) rdata_q <= mem_q[addr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-requester round-robin SRAM arbiter; define SRAM_ARBITER_INIT_EN to zero-fill storage after reset
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  req0_rvalid,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  req1_rvalid,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  init_done
);
  state_e                state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_WIDTH-1:0] hold0_q, hold0_d, hold1_q, hold1_d;
  logic                  g0, g1, mem_we, mem_re, sweep_we;
  logic [ADDR_WIDTH-1:0] mem_addr, sweep_addr;
  logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;

  assign init_done = state_q == RUN;

`ifdef SRAM_ARBITER_INIT_EN
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  // sweep every address once, then start serving requests
  always_comb begin
    cnt_d      = init_done ? cnt_q : cnt_q + 1'b1;
    state_d    = (init_done || cnt_q == '1) ? RUN : INIT;
    sweep_we   = ~init_done;
    sweep_addr = cnt_q;
  end
  // sweep address restarts from zero on every reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  // no sweep: serve requests from the first edge after reset
  always_comb begin
    state_d    = RUN;
    sweep_we   = 1'b0;
    sweep_addr = '0;
  end
`endif

  // grant, pointer update, storage port steering and read-data hold
  always_comb begin
    g0        = init_done & req0_valid & (~req1_valid | ~ptr_q);
    g1        = init_done & req1_valid & (~req0_valid | ptr_q);
    ptr_d     = g0 ? 1'b1 : g1 ? 1'b0 : ptr_q;
    rvalid0_d = g0 & ~req0_we;
    rvalid1_d = g1 & ~req1_we;
    hold0_d   = rvalid0_q ? mem_rdata : hold0_q;
    hold1_d   = rvalid1_q ? mem_rdata : hold1_q;
    mem_we    = sweep_we | (g0 & req0_we) | (g1 & req1_we);
    mem_re    = rvalid0_d | rvalid1_d;
    mem_addr  = !init_done ? sweep_addr : g1 ? req1_addr : req0_addr;
    mem_wdata = !init_done ? '0 : g1 ? req1_wdata : req0_wdata;
  end

  // control state; reset drops any read still in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT;
      ptr_q     <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      hold0_q   <= '0;
      hold1_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      hold0_q   <= hold0_d;
      hold1_q   <= hold1_d;
    end
  end

  sram_mem #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .re   (mem_re),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  assign req0_ready  = g0;
  assign req1_ready  = g1;
  assign req0_rvalid = rvalid0_q;
  assign req1_rvalid = rvalid1_q;
  assign req0_rdata  = rvalid0_q ? mem_rdata : hold0_q;
  assign req1_rdata  = rvalid1_q ? mem_rdata : hold1_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: table-driven check of sram_arbiter with a read-data scoreboard; honours SRAM_ARBITER_INIT_EN
module tb_sram_arbiter;
  typedef struct packed {
    logic v0, we0; logic [3:0] a0; logic [7:0] d0;
    logic v1, we1; logic [3:0] a1; logic [7:0] d1;
    logic r0, r1;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic v0, we0, v1, we1, r0, r1, rv0, rv1, init_done;
  logic [3:0] a0, a1;
  logic [7:0] d0, d1, rd0, rd1;
  int total = 0, bad = 0;
  logic [7:0] mdl [16];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] last0 = 8'h00, last1 = 8'h00;
  vec_t tbl [17];
  vec_t v;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_we(we0), .req0_addr(a0), .req0_wdata(d0),
    .req0_ready(r0), .req0_rvalid(rv0), .req0_rdata(rd0),
    .req1_valid(v1), .req1_we(we1), .req1_addr(a1), .req1_wdata(d1),
    .req1_ready(r1), .req1_rvalid(rv1), .req1_rdata(rd1),
    .init_done(init_done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t x);
    {v0, we0, a0, d0, v1, we1, a1, d1} = {x.v0, x.we0, x.a0, x.d0, x.v1, x.we1, x.a1, x.d1};
  endtask

  task automatic outs();
    logic [7:0] e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("rvalid0", rv0, 1);
      chk("rdata0", rd0, e);
      last0 = e;
    end else begin
      chk("rvalid0", rv0, 0);
      chk("rdata0_hold", rd0, last0);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("rvalid1", rv1, 1);
      chk("rdata1", rd1, e);
      last1 = e;
    end else begin
      chk("rvalid1", rv1, 0);
      chk("rdata1_hold", rd1, last1);
    end
  endtask

  task automatic cyc(input vec_t x);
    @(posedge clk);
    #1 drive(x);
    @(negedge clk);
    outs();
    chk("ready0", r0, x.r0);
    chk("ready1", r1, x.r1);
    if (x.r0) begin
      if (x.we0) mdl[x.a0] = x.d0;
      else q0.push_back(mdl[x.a0]);
    end
    if (x.r1) begin
      if (x.we1) mdl[x.a1] = x.d1;
      else q1.push_back(mdl[x.a1]);
    end
  endtask

  task automatic post_release();
`ifdef SRAM_ARBITER_INIT_EN
    for (int k = 0; k < 16; k++) begin
      #1 chk("init_ready0", r0, 0);
      chk("init_done_low", init_done, 0);
      @(posedge clk);
    end
    #1 drive('0);
    chk("init_done", init_done, 1);
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
`else
    @(posedge clk);
    #1 drive('0);
    chk("init_done", init_done, 1);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    last0 = 8'h00;
    last1 = 8'h00;
    drive({1'b1, 1'b0, 4'd3, 8'h00, 1'b1, 1'b0, 4'd7, 8'h00, 1'b0, 1'b0});
    #1;
    chk("rst_ready0", r0, 0);
    chk("rst_ready1", r1, 0);
    chk("rst_rvalid0", rv0, 0);
    chk("rst_rvalid1", rv1, 0);
    chk("rst_rdata0", rd0, 0);
    chk("rst_rdata1", rd1, 0);
    chk("rst_init_done", init_done, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    post_release();
  endtask

  initial begin
    tbl[0]  = {1'b1, 1'b1, 4'd3, 8'hA5, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0};
    tbl[1]  = {1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0};
    tbl[2]  = {1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0};
    tbl[3]  = {1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 4'd7, 8'h3C, 1'b0, 1'b1};
    tbl[4]  = {1'b1, 1'b0, 4'd7, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0};
    tbl[5]  = {1'b1, 1'b1, 4'd1, 8'h11, 1'b1, 1'b1, 4'd2, 8'h22, 1'b0, 1'b1};
    tbl[6]  = {1'b1, 1'b1, 4'd1, 8'h11, 1'b1, 1'b0, 4'd2, 8'h00, 1'b1, 1'b0};
    tbl[7]  = {1'b1, 1'b0, 4'd1, 8'h00, 1'b1, 1'b0, 4'd2, 8'h00, 1'b0, 1'b1};
    tbl[8]  = {1'b1, 1'b0, 4'd1, 8'h00, 1'b1, 1'b0, 4'd2, 8'h00, 1'b1, 1'b0};
    tbl[9]  = {1'b1, 1'b1, 4'd4, 8'h44, 1'b1, 1'b1, 4'd4, 8'h55, 1'b0, 1'b1};
    tbl[10] = {1'b1, 1'b0, 4'd4, 8'h00, 1'b1, 1'b0, 4'd4, 8'h00, 1'b1, 1'b0};
    tbl[11] = {1'b0, 1'b1, 4'd4, 8'hFF, 1'b1, 1'b0, 4'd4, 8'h00, 1'b0, 1'b1};
    tbl[12] = {1'b0, 1'b1, 4'd4, 8'hFF, 1'b0, 1'b1, 4'd4, 8'hEE, 1'b0, 1'b0};
    tbl[13] = {1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd4, 8'h00, 1'b0, 1'b1};
    tbl[14] = {1'b1, 1'b0, 4'd7, 8'h00, 1'b1, 1'b0, 4'd1, 8'h00, 1'b1, 1'b0};
    tbl[15] = {1'b1, 1'b0, 4'd7, 8'h00, 1'b1, 1'b0, 4'd1, 8'h00, 1'b0, 1'b1};
    tbl[16] = {1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0};
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    do_reset();
`ifdef SRAM_ARBITER_INIT_EN
    repeat (5) @(posedge clk);
    do_reset();
    for (int i = 0; i < 16; i++)
      cyc({1'b1, 1'b0, 4'(i), 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0});
    cyc({1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1});
`endif
    for (int i = 0; i < 17; i++) cyc(tbl[i]);
    cyc({1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0});
    @(posedge clk);
    #1 chk("pre_rst_rvalid0", rv0, 1);
    do_reset();
    for (int k = 0; k < 8; k++) begin
      bit e;
      e = k[0];
      v = {1'b1, 1'b0, 4'd3, 8'h00, 1'b1, 1'b0, 4'd7, 8'h00, ~e, e};
      cyc(v);
    end
    cyc('0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, word address width (16 locations).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, data word width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req0_valid/req1_valid  input  1  requester N presents a request.
REQ-006 SHALL have ports req0_we/req1_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports req0_addr/req1_addr  input  ADDR_WIDTH  target word address.
REQ-008 SHALL have ports req0_wdata/req1_wdata  input  DATA_WIDTH  write data.
REQ-009 SHALL have ports req0_ready/req1_ready  output  1  request accepted this cycle when valid and ready.
REQ-010 SHALL have ports req0_rvalid/req1_rvalid  output  1  one-cycle pulse, read data valid.
REQ-011 SHALL have ports req0_rdata/req1_rdata  output  DATA_WIDTH  read data, held until next read to that requester.
REQ-012 SHALL have port init_done  output  1  arbiter is accepting requests.

Function
REQ-013 SHALL grant at most one requester per cycle; readyN is high only for the granted requester, combinationally from valid inputs and priority pointer.
REQ-014 SHALL arbitrate round-robin: a lone valid is granted; on simultaneous valids the requester named by the 1-bit priority pointer wins.
REQ-015 SHALL move the pointer to the other requester after every accepted transfer, and leave it unchanged on idle cycles.
REQ-016 SHALL perform the storage access on the handshake edge; a write updates the addressed word at that edge.
REQ-017 SHALL return read data with latency 1: rvalidN high exactly the cycle after the accepted read, rdataN valid that cycle.
REQ-018 SHALL sustain one accepted transfer per cycle with no bubbles, alternating under contention.
REQ-019 SHALL return newly written data for a read accepted the cycle after a write to the same address (either requester).
REQ-020 SHALL hold both ready outputs low while init_done is low.
REQ-021 SHALL ignore we/addr/wdata of a requester whose valid is low or which is not granted.

Reset
REQ-022 SHALL, with rst_n low, drive ready=0, rvalid=0, rdata=0 on both requesters, pointer=0 (requester 0 favoured), init_done=0.
REQ-023 SHALL, on reset asserted mid-operation, drop any pending rvalid immediately; a read accepted in the prior cycle is not answered.
REQ-024 SHALL NOT reset the storage array contents.

Configuration
REQ-025 SHALL support macro SRAM_ARBITER_INIT_EN.
REQ-026 SHALL, with SRAM_ARBITER_INIT_EN defined, after reset release sweep addresses 0..2^ADDR_WIDTH-1 writing zero, one per cycle, then raise init_done (16 cycles at default).
REQ-027 SHALL, without SRAM_ARBITER_INIT_EN, raise init_done on the first clock edge after reset release with contents undefined.
REQ-028 SHALL, if reset asserts during the sweep, restart the sweep from address 0 after release.

Structure
REQ-029 SHALL take default widths and the FSM state enum (INIT, RUN) from shared package sram_pkg.
REQ-030 SHALL instantiate storage as one sub-module sram_mem (synchronous write, registered read); arbiter logic stays in sram_arbiter.

Verification
REQ-031 SHALL cover: req0 write addr 3 data 0xA5, then req0 read addr 3 -> req0_rvalid one cycle after accept, rdata 0xA5.
REQ-032 SHALL cover: both valid continuously after reset -> grants 0,1,0,1...; one transfer per cycle.
REQ-033 SHALL cover: req1 write addr 7 = 0x3C cycle N, req0 read addr 7 cycle N+1 -> req0_rdata 0x3C at N+2.
REQ-034 SHALL cover: reset asserted cycle after an accepted read -> no rvalid, all outputs zero asynchronously.
REQ-035 SHALL cover, with SRAM_ARBITER_INIT_EN: ready low 16 cycles after release, then read every address -> 0x00.
REQ-036 SHALL cover: only req1 valid while pointer favours 0 -> req1 granted immediately, pointer moves to 0.
